// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Frames host bytes onto the UART transmit line. Each frame is a start bit,
// DATA_BITS data bits sent LSB first, an optional parity bit and one stop bit.
// Every bit lasts 16 ticks of the baud generator's sample_ENABLE strobe.
// A one-entry holding register lets the host queue the next byte while a
// frame is on the wire, so back-to-back frames leave no idle gap.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset (0 = reset)
//   Tx_EN          transmitter enable; only gates the start of a frame
//   Tx_WR          one-cycle write strobe qualifying Tx_DATA
//   Tx_DATA        byte to transmit
//   sample_ENABLE  16x baud tick, one clk wide
//   Tx_D           registered serial output, idles high
//   Tx_BUSY        high while a frame is in progress
//   Tx_FULL        holding register occupied
//   Tx_DONE        one-cycle pulse at the end of every stop bit
//   Tx_OVR         one-cycle pulse when a write is dropped (holding full)
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic                 sample_ENABLE,
    output logic                 Tx_D,
    output logic                 Tx_BUSY,
    output logic                 Tx_FULL,
    output logic                 Tx_DONE,
    output logic                 Tx_OVR
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       PAR_EN   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    state_t               state,    state_next;
    logic [3:0]           tick_cnt, tick_next;
    logic [2:0]           bit_cnt,  bit_next;
    logic [DATA_BITS-1:0] shift_q,  shift_next;
    logic [DATA_BITS-1:0] hold_q,   hold_next;
    logic                 parity_q, parity_next;
    logic                 full_q,   full_next;
    logic                 tx_d_q,   tx_d_next;
    logic                 done_q,   done_next;
    logic                 ovr_q,    ovr_next;

    logic                 bit_end;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_next  = state;
        tick_next   = tick_cnt;
        bit_next    = bit_cnt;
        shift_next  = shift_q;
        hold_next   = hold_q;
        parity_next = parity_q;
        full_next   = full_q;
        done_next   = 1'b0;
        ovr_next    = 1'b0;
        load        = 1'b0;
        tx_d_next   = 1'b1;

        bit_end   = (state != IDLE) && sample_ENABLE && (tick_cnt == 4'd15);
        // A queued byte always goes out before the one being written now.
        load_data = full_q ? hold_q : Tx_DATA;

        // The 4-bit counter wraps to 0 by itself on the 16th tick.
        if ((state != IDLE) && sample_ENABLE) begin
            tick_next = tick_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                load = Tx_EN && (Tx_WR || full_q);
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_q >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_next   = 3'd0;
                        state_next = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    done_next = 1'b1;
                    // Chain straight into the next frame when a byte is
                    // available, otherwise drop back to idle.
                    load = Tx_EN && (Tx_WR || full_q);
                    if (!load) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            state_next  = START;
            tick_next   = 4'd0;
            bit_next    = 3'd0;
            shift_next  = load_data;
            parity_next = (^load_data) ^ PAR_ODD;
        end

        // Host write path. When the holding byte is consumed in the same
        // cycle as a write, the new byte takes its place without overrun.
        // When the holding register is empty and a frame loads, the write
        // itself was consumed into the shift register above.
        if (load && full_q) begin
            full_next = Tx_WR;
            if (Tx_WR) hold_next = Tx_DATA;
        end else if (Tx_WR && !load) begin
            if (full_q) begin
                ovr_next = 1'b1;
            end else begin
                hold_next = Tx_DATA;
                full_next = 1'b1;
            end
        end

        // Line level follows the state being entered, so Tx_D is registered
        // and changes on the same edge as the state.
        case (state_next)
            START:   tx_d_next = 1'b0;
            DATA:    tx_d_next = shift_next[0];
            PARITY:  tx_d_next = parity_next;
            default: tx_d_next = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            shift_q  <= '0;
            hold_q   <= '0;
            parity_q <= 1'b0;
            full_q   <= 1'b0;
            tx_d_q   <= 1'b1;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shift_q  <= shift_next;
            hold_q   <= hold_next;
            parity_q <= parity_next;
            full_q   <= full_next;
            tx_d_q   <= tx_d_next;
            done_q   <= done_next;
            ovr_q    <= ovr_next;
        end
    end

    assign Tx_D    = tx_d_q;
    assign Tx_BUSY = (state != IDLE);
    assign Tx_FULL = full_q;
    assign Tx_DONE = done_q;
    assign Tx_OVR  = ovr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_scheduler.
// A line monitor decodes every frame on Tx_D and compares it against a
// scoreboard of bytes pushed when the stimulus writes them. Directed checks
// cover reset, frame timing, queuing, overrun, enable gating and abort.
// A second instance with odd parity shares the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       sample_ENABLE = 1'b0;
    logic       Tx_D, Tx_BUSY, Tx_FULL, Tx_DONE, Tx_OVR;
    logic       odd_d, odd_busy, odd_full, odd_done, odd_ovr;

    uart_tx_scheduler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .Tx_EN         (Tx_EN),
        .Tx_WR         (Tx_WR),
        .Tx_DATA       (Tx_DATA),
        .sample_ENABLE (sample_ENABLE),
        .Tx_D          (Tx_D),
        .Tx_BUSY       (Tx_BUSY),
        .Tx_FULL       (Tx_FULL),
        .Tx_DONE       (Tx_DONE),
        .Tx_OVR        (Tx_OVR)
    );

    uart_tx_scheduler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk           (clk),
        .reset         (reset),
        .Tx_EN         (Tx_EN),
        .Tx_WR         (Tx_WR),
        .Tx_DATA       (Tx_DATA),
        .sample_ENABLE (sample_ENABLE),
        .Tx_D          (odd_d),
        .Tx_BUSY       (odd_busy),
        .Tx_FULL       (odd_full),
        .Tx_DONE       (odd_done),
        .Tx_OVR        (odd_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames = 0;
    int ovr_cnt  = 0;
    int div      = 1;
    int se_cnt   = 0;

    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Tick generator: one pulse every div clocks, driven away from posedge.
    always @(negedge clk) begin
        if (se_cnt >= div - 1) begin
            se_cnt        = 0;
            sample_ENABLE = 1'b1;
        end else begin
            se_cnt++;
            sample_ENABLE = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (Tx_OVR) ovr_cnt++;
    end

    // Line monitor: find the start edge, sample each bit in its middle.
    logic       mon_active = 1'b0;
    logic       prev_d     = 1'b1;
    int         mon_cnt    = 0;
    int         mon_k      = 0;
    logic [7:0] mon_data   = '0;
    logic       mon_par    = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
            prev_d     = 1'b1;
        end else begin
            if (!mon_active) begin
                if (prev_d && !Tx_D) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_k      = 0;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_active && (mon_cnt == mon_k * 16 * div + 8 * div)) begin
                if (mon_k == 0) begin
                    check("mon_start", Tx_D, 0);
                end else if (mon_k <= 8) begin
                    mon_data[mon_k-1] = Tx_D;
                end else if (mon_k == 9) begin
                    mon_par = Tx_D;
                end else begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    exp_b = 8'h00;
                    if (sb.size() != 0) exp_b = sb.pop_front();
                    check("mon_data", mon_data, exp_b);
                    check("mon_parity", mon_par, ^exp_b);
                    check("mon_stop", Tx_D, 1);
                    n_frames++;
                    mon_active = 1'b0;
                end
                mon_k++;
            end
            prev_d = Tx_D;
        end
    end

    // Write for one cycle; call at a negedge, returns at the next negedge.
    task automatic put(input logic [7:0] b, input bit expect_tx);
        Tx_WR   = 1'b1;
        Tx_DATA = b;
        if (expect_tx) sb.push_back(b);
        @(negedge clk);
        Tx_WR = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!Tx_DONE && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, Tx_DONE, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (Tx_BUSY && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, Tx_BUSY, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int ovr_base;

        reset   = 1'b0;
        Tx_EN   = 1'b1;
        Tx_WR   = 1'b0;
        Tx_DATA = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_d", Tx_D, 1);
        check("rst_busy", Tx_BUSY, 0);
        check("rst_full", Tx_FULL, 0);
        check("rst_done", Tx_DONE, 0);
        check("rst_ovr", Tx_OVR, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, tick every clock: 11 bits x 16 = 176 clocks busy.
        put(8'hA5, 1);
        check("t1_start_d", Tx_D, 0);
        check("t1_busy", Tx_BUSY, 1);
        n = 1;
        while (Tx_BUSY && n < 400) begin
            @(negedge clk);
            if (Tx_BUSY) n++;
        end
        check("t1_len", n, 176);
        check("t1_done", Tx_DONE, 1);
        @(negedge clk);
        check("t1_done_pulse", Tx_DONE, 0);

        // Queued byte chains into a second frame with no idle bit.
        repeat (4) @(negedge clk);
        put(8'h3C, 1);
        repeat (19) @(negedge clk);
        put(8'h81, 1);
        check("t2_full", Tx_FULL, 1);
        wait_done(300, "t2_done1");
        check("t2_chain_busy", Tx_BUSY, 1);
        check("t2_chain_d", Tx_D, 0);
        check("t2_chain_full", Tx_FULL, 0);
        @(negedge clk);
        wait_done(300, "t2_done2");
        check("t2_idle", Tx_BUSY, 0);

        // Three consecutive writes: first sends, second queues, third drops.
        repeat (4) @(negedge clk);
        ovr_base = ovr_cnt;
        put(8'h11, 1);
        put(8'h22, 1);
        put(8'h33, 0);
        check("t3_ovr", Tx_OVR, 1);
        check("t3_full", Tx_FULL, 1);
        @(negedge clk);
        check("t3_ovr_pulse", Tx_OVR, 0);
        wait_done(300, "t3_done1");
        @(negedge clk);
        wait_done(300, "t3_done2");
        check("t3_ovr_count", ovr_cnt - ovr_base, 1);

        // Slow tick (every 4th clk): 64 clocks per bit; parity of 0x07.
        repeat (4) @(negedge clk);
        div = 4;
        repeat (6) @(negedge clk);
        put(8'h07, 1);
        repeat (608) @(negedge clk);
        check("t4_odd_parity", odd_d, 0);
        check("t4_even_parity", Tx_D, 1);
        n = 609;
        while (Tx_BUSY && n < 1000) begin
            @(negedge clk);
            if (Tx_BUSY) n++;
        end
        check("t4_len_ok", (n >= 701 && n <= 704), 1);
        check("t4_done", Tx_DONE, 1);
        div = 1;
        repeat (6) @(negedge clk);

        // Enable dropped mid-frame with a byte queued.
        put(8'h44, 1);
        put(8'h55, 1);
        repeat (48) @(negedge clk);
        Tx_EN = 1'b0;
        wait_idle(300, "t5_idle");
        check("t5_full", Tx_FULL, 1);
        check("t5_line", Tx_D, 1);
        repeat (20) @(negedge clk);
        check("t5_hold_busy", Tx_BUSY, 0);
        check("t5_hold_full", Tx_FULL, 1);
        Tx_EN = 1'b1;
        @(negedge clk);
        check("t5_restart_busy", Tx_BUSY, 1);
        check("t5_restart_d", Tx_D, 0);
        check("t5_restart_full", Tx_FULL, 0);
        wait_idle(300, "t5_end");

        // Reset during data bit 3 aborts the frame and loses the queue.
        repeat (4) @(negedge clk);
        put(8'hC3, 0);
        put(8'h99, 0);
        repeat (68) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_abort_d", Tx_D, 1);
        check("t6_abort_busy", Tx_BUSY, 0);
        check("t6_abort_full", Tx_FULL, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_restart", Tx_BUSY, 0);
        put(8'h5A, 1);
        check("t6_start_d", Tx_D, 0);
        wait_idle(300, "t6_end");

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("frame_count", n_frames, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
